traffic_light_ctrl_n: RTL and testbench
=======================================

# traffic_light_ctrl_n

Parametrised, demand-actuated N-approach traffic light controller, the successor to the fixed four-way junction sequencer. It sequences one approach at a time through green, yellow and all-red clearance, skipping approaches with no vehicle request. It holds green while no other approach is waiting and supports an emergency all-red override. Timing is driven by an external `tick` enable from a shared prescaler, so the block contains no clock divider.

## Interface
- `NUM_DIR`, 4: number of approaches; legal range 2..16.
- `CNT_W`, 8: width of the phase tick counter.
- `GREEN_TICKS`, 8: minimum green duration in ticks; legal range 1..2^CNT_W-1.
- `YELLOW_TICKS`, 2: yellow duration in ticks; same legal range.
- `ALLRED_TICKS`, 1: all-red clearance duration in ticks; same legal range.
- `clk_in` in 1: system clock; all state updates on the rising edge.
- `rst_a` in 1: asynchronous, active-high reset.
- `tick` in 1: single-cycle timing enable; counters advance only when it is high.
- `req` in NUM_DIR: per-approach demand (level); bit i corresponds to approach i.
- `emerg` in 1: emergency override (level).
- `lights` out 3*NUM_DIR: bits [3i+2:3i] belong to approach i; 3'b001 is green, 3'b010 is yellow, 3'b100 is red.
- `active_dir` out $clog2(NUM_DIR): approach currently granted (green or yellow); holds the last granted approach during all-red.
- `phase` out 2: 2'b00 is GREEN, 2'b01 is YELLOW, 2'b10 is ALLRED; 2'b11 is never driven.

## Operation
- State machine: GREEN → YELLOW → ALLRED → GREEN (next approach). Registers: state, `count` (CNT_W bits), `last_dir`.
- Counting on each `tick`:
  - If `count == DUR-1` for the current state, the state transitions and `count` becomes 0.
  - Otherwise `count` increments.
  - Each state therefore lasts exactly DUR ticks unless extended.
- GREEN:
  - At `count == GREEN_TICKS-1`, go to YELLOW only if some other approach has `req` high.
  - If no other approach has `req` high, remain in GREEN with `count` saturated at GREEN_TICKS-1. The owning approach's own `req` is irrelevant.
  - Once saturated, the first tick on which another `req` is high moves the state to YELLOW.
- YELLOW: lasts YELLOW_TICKS ticks, then goes to ALLRED.
- ALLRED:
  - All approaches show red. After ALLRED_TICKS ticks, go to GREEN on the next approach.
  - Next approach: search round-robin starting at `last_dir+1` (mod NUM_DIR) for the first index with `req` high, sampled on the transition tick.
  - If no `req` bit is high, grant `last_dir+1` (mod NUM_DIR), giving plain rotation.
  - `last_dir` and `active_dir` update on entry to GREEN.
- Emergency:
  - `emerg` high in GREEN: on the next tick go to YELLOW with `count` = 0, regardless of minimum green.
  - `emerg` high in YELLOW: yellow completes normally.
  - `emerg` high in ALLRED: `count` is held at 0 and no exit occurs.
  - After `emerg` falls, ALLRED runs a full ALLRED_TICKS before the next GREEN.
  - `emerg` has priority over green hold/extension.
- Lights decode from state and `active_dir`:
  - In GREEN or YELLOW, `active_dir` shows 001 or 010 respectively and every other approach shows 100.
  - In ALLRED, every approach shows 100.
  - Exactly one approach is ever non-red.
- `req` and `emerg` are synchronous to `clk_in`; the upstream sensor logic provides synchronisation.

## Timing
- Reset values, applied immediately on `rst_a` assertion:
  - state ALLRED, `count` 0, `last_dir` NUM_DIR-1;
  - `active_dir` NUM_DIR-1, `phase` 2'b10;
  - `lights` all 3'b100.
- The first GREEN after reset is approach 0 if `req[0]` is high.
- Reset asserted mid-operation forces all-red in the same cycle, with no yellow.
- State, `lights`, `phase` and `active_dir` are all registered and change on the same `clk_in` edge as the qualifying tick. Latency from the transition tick to the new outputs is 0 cycles, i.e. the same edge.
- Cycles with `tick` low leave every register unchanged, including the emergency entry from GREEN.

## Test plan
- NUM_DIR=4, G=4, Y=2, AR=1, `tick`=1 every cycle, `req`=4'b1111, reset released:
  - `lights`=12'h924 for 1 cycle;
  - then 12'h921 for 4 cycles, then 12'h922 for 2 cycles;
  - then 12'h924 for 1 cycle, then 12'h90C (approach 1 green).
- Skip: `req`=4'b1001. After approach 0 yellow and all-red, approach 3 goes green (`active_dir`=3); approaches 1 and 2 are never granted.
- Hold: `req`=4'b0001 leaves approach 0 green for 50 cycles. Raising `req[2]` gives yellow on the next edge, then all-red, then approach 2 green.
- Emergency: `emerg` raised at GREEN `count`=1:
  - next edge gives yellow for 2 cycles, then all-red held for 20 cycles;
  - after `emerg` falls, all-red lasts 1 more cycle, then the next requested approach goes green.
- Tick gating: `tick` high one cycle in three gives a green lasting 12 clock cycles. Asserting `rst_a` mid-yellow gives `lights`=12'h924 and `phase`=2'b10 immediately; after release, approach 0 is granted first.

Source files
------------

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n
//
// Demand-actuated traffic light controller for NUM_DIR approaches. One
// approach at a time runs GREEN -> YELLOW -> ALLRED; the next approach is
// chosen round-robin among those with a pending request, so approaches
// without demand are skipped. Green is held for as long as no other
// approach is waiting. An emergency input forces the junction to all-red
// and keeps it there. All timing advances only on the external `tick`
// enable; the block has no clock divider of its own.
//
// Ports
//   clk_in      in   system clock, rising edge
//   rst_a       in   asynchronous active-high reset (forces all-red at once)
//   tick        in   single-cycle timing enable from a shared prescaler
//   req         in   [NUM_DIR-1:0] per-approach demand, level
//   emerg       in   emergency override, level
//   lights      out  [3*NUM_DIR-1:0] 3 bits per approach:
//                    001 green, 010 yellow, 100 red
//   active_dir  out  approach granted green/yellow; holds the last grant
//                    through all-red
//   phase       out  00 GREEN, 01 YELLOW, 10 ALLRED (11 never driven);
//                    this is the state register, exposed for observation
//
// All outputs are registered and are loaded from the next-state values, so
// they change on the same clk_in edge as the tick that causes a transition.

module traffic_light_ctrl_n #(
  parameter int NUM_DIR      = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1
) (
  input  logic                         clk_in,
  input  logic                         rst_a,
  input  logic                         tick,
  input  logic [NUM_DIR-1:0]           req,
  input  logic                         emerg,
  output logic [3*NUM_DIR-1:0]         lights,
  output logic [$clog2(NUM_DIR)-1:0]   active_dir,
  output logic [1:0]                   phase
);

  localparam int DIR_W = $clog2(NUM_DIR);

  // Last count value of each phase; reaching it on a tick ends the phase.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);

  localparam logic [DIR_W-1:0] DIR_MAX = DIR_W'(NUM_DIR - 1);

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [DIR_W-1:0]   last_dir;

  state_t             state_n;
  logic [CNT_W-1:0]   count_n;
  logic [DIR_W-1:0]   dir_n;

  logic [NUM_DIR-1:0] own_mask;
  logic               other_req;
  logic [DIR_W-1:0]   rr_dir;
  logic               rr_found;
  logic [DIR_W-1:0]   dir_plus1;

  // Lamp pattern for a given state and owning approach. Only the owner may
  // be non-red, and only outside ALLRED.
  function automatic logic [3*NUM_DIR-1:0] decode_lights(
    input state_t           s,
    input logic [DIR_W-1:0] d
  );
    logic [3*NUM_DIR-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (s == ST_ALLRED || DIR_W'(i) != d) begin
        l[3*i +: 3] = LAMP_RED;
      end else if (s == ST_GREEN) begin
        l[3*i +: 3] = LAMP_GREEN;
      end else begin
        l[3*i +: 3] = LAMP_YELLOW;
      end
    end
    return l;
  endfunction

  // Demand from any approach other than the current owner. The owner's own
  // request never shortens its green.
  always_comb begin
    own_mask  = NUM_DIR'(1) << last_dir;
    other_req = |(req & ~own_mask);
  end

  // Plain rotation target, used when nobody is requesting.
  always_comb begin
    dir_plus1 = (last_dir == DIR_MAX) ? '0 : last_dir + DIR_W'(1);
  end

  // Round-robin search starting one past the last grant. The owner itself
  // is visited last, so it is re-granted only if it is the sole requester.
  always_comb begin
    int idx;
    rr_dir   = dir_plus1;
    rr_found = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = (int'(last_dir) + k) % NUM_DIR;
      if (!rr_found && req[idx]) begin
        rr_dir   = DIR_W'(idx);
        rr_found = 1'b1;
      end
    end
  end

  // Next-state logic. Nothing moves without a tick, including emergency
  // entry from GREEN.
  always_comb begin
    state_n = state;
    count_n = count;
    dir_n   = last_dir;
    if (tick) begin
      unique case (state)
        ST_GREEN: begin
          if (emerg) begin
            // Emergency cuts the green short regardless of minimum time.
            state_n = ST_YELLOW;
            count_n = '0;
          end else if (count == GREEN_LAST) begin
            if (other_req) begin
              state_n = ST_YELLOW;
              count_n = '0;
            end
            // Otherwise hold green with the counter parked at its last
            // value so the first competing request ends it on one tick.
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        ST_YELLOW: begin
          // Yellow always runs to completion, emergency or not.
          if (count == YELLOW_LAST) begin
            state_n = ST_ALLRED;
            count_n = '0;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        ST_ALLRED: begin
          if (emerg) begin
            // Park at zero: once emerg drops, a full clearance interval
            // elapses before any approach goes green.
            count_n = '0;
          end else if (count == ALLRED_LAST) begin
            state_n = ST_GREEN;
            count_n = '0;
            dir_n   = rr_dir;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        default: begin
          // Unreachable encoding: recover to a safe all-red.
          state_n = ST_ALLRED;
          count_n = '0;
        end
      endcase
    end
  end

  // Single state register block; outputs are registered from next-state
  // values so they track the state with no extra cycle of latency.
  always_ff @(posedge clk_in or posedge rst_a) begin
    if (rst_a) begin
      state      <= ST_ALLRED;
      count      <= '0;
      last_dir   <= DIR_MAX;
      active_dir <= DIR_MAX;
      phase      <= 2'b10;
      lights     <= {NUM_DIR{LAMP_RED}};
    end else begin
      state      <= state_n;
      count      <= count_n;
      last_dir   <= dir_n;
      active_dir <= dir_n;
      phase      <= state_n;
      lights     <= decode_lights(state_n, dir_n);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Testbench for traffic_light_ctrl_n with NUM_DIR=4, G=4, Y=2, AR=1.
// Each cycle the driver applies inputs, pushes the expected post-edge
// {lights, phase, active_dir} onto the scoreboard queue, and after the edge
// pops and compares.

module tb_traffic_light_ctrl_n;

  localparam int NUM_DIR = 4;
  localparam int W       = 16;  // {lights[11:0], phase[1:0], dir[1:0]}

  // Expected lamp patterns (approach 3 in the top bits).
  localparam logic [11:0] L_AR = 12'h924;
  localparam logic [11:0] G0   = 12'h921;
  localparam logic [11:0] Y0   = 12'h922;
  localparam logic [11:0] G1   = 12'h90C;
  localparam logic [11:0] G2   = 12'h864;
  localparam logic [11:0] G3   = 12'h324;
  localparam logic [11:0] Y3   = 12'h524;

  localparam logic [1:0] P_G  = 2'b00;
  localparam logic [1:0] P_Y  = 2'b01;
  localparam logic [1:0] P_AR = 2'b10;

  // ---------------- clock / reset ----------------
  logic        clk_in = 1'b0;
  logic        rst_a  = 1'b1;
  logic        tick   = 1'b0;
  logic [3:0]  req    = 4'b0000;
  logic        emerg  = 1'b0;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [1:0]  phase;

  always #5 clk_in = ~clk_in;

  traffic_light_ctrl_n #(
    .NUM_DIR(NUM_DIR), .CNT_W(8),
    .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1)
  ) dut (
    .clk_in(clk_in), .rst_a(rst_a), .tick(tick), .req(req), .emerg(emerg),
    .lights(lights), .active_dir(active_dir), .phase(phase)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic compare_out(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".lights"}, lights, e[15:4]);
      check({tag, ".phase"}, {10'd0, phase}, {10'd0, e[3:2]});
      check({tag, ".dir"}, {10'd0, active_dir}, {10'd0, e[1:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; inputs settle well before the next edge.
  task automatic step(input string tag, input logic t, input logic [3:0] r,
                      input logic e, input logic [11:0] el,
                      input logic [1:0] ep, input logic [1:0] ed);
    tick  = t;
    req   = r;
    emerg = e;
    exp_q.push_back({el, ep, ed});
    @(posedge clk_in);
    #1;
    compare_out(tag);
  endtask

  // Asserts reset away from the clock edge, checks the outputs respond
  // without waiting for a clock, then releases after one edge.
  task automatic do_reset(input string tag);
    rst_a = 1'b1;
    tick  = 1'b1;
    req   = 4'b1111;
    emerg = 1'b0;
    #1;
    exp_q.push_back({L_AR, P_AR, 2'd3});
    compare_out({tag, ".async"});
    @(posedge clk_in);
    #1;
    exp_q.push_back({L_AR, P_AR, 2'd3});
    compare_out({tag, ".held"});
    rst_a = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        tick;
    logic [3:0]  req;
    logic        emerg;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic [1:0]  dir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic t, input logic [3:0] r,
                              input logic e, input logic [11:0] l,
                              input logic [1:0] p, input logic [1:0] d);
    vec_t v;
    v.tick = t; v.req = r; v.emerg = e; v.lights = l; v.phase = p; v.dir = d;
    return v;
  endfunction

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("%s[%0d]", tag, i), tbl[i].tick, tbl[i].req,
           tbl[i].emerg, tbl[i].lights, tbl[i].phase, tbl[i].dir);
    tbl.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    @(posedge clk_in);
    #1;

    // Basic cycle, all approaches requesting: 924, 4x921, 2x922, 924, 90C.
    do_reset("rst1");
    tbl.push_back(mk(1, 4'b1111, 0, G0,   P_G,  0));
    tbl.push_back(mk(1, 4'b1111, 0, G0,   P_G,  0));
    tbl.push_back(mk(1, 4'b1111, 0, G0,   P_G,  0));
    tbl.push_back(mk(1, 4'b1111, 0, G0,   P_G,  0));
    tbl.push_back(mk(1, 4'b1111, 0, Y0,   P_Y,  0));
    tbl.push_back(mk(1, 4'b1111, 0, Y0,   P_Y,  0));
    tbl.push_back(mk(1, 4'b1111, 0, L_AR, P_AR, 0));
    tbl.push_back(mk(1, 4'b1111, 0, G1,   P_G,  1));
    run_table("basic");

    // Skip: only approaches 0 and 3 request; 3 follows 0, then wraps to 0.
    do_reset("rst2");
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 4'b1001, 0, G0, P_G, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 4'b1001, 0, Y0, P_Y, 0));
    tbl.push_back(mk(1, 4'b1001, 0, L_AR, P_AR, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 4'b1001, 0, G3, P_G, 3));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 4'b1001, 0, Y3, P_Y, 3));
    tbl.push_back(mk(1, 4'b1001, 0, L_AR, P_AR, 3));
    tbl.push_back(mk(1, 4'b1001, 0, G0,   P_G,  0));
    run_table("skip");

    // Hold: sole requester keeps green; a competing request ends it next tick.
    do_reset("rst3");
    for (int i = 0; i < 50; i++)
      step($sformatf("hold[%0d]", i), 1, 4'b0001, 0, G0, P_G, 0);
    step("hold.y0", 1, 4'b0101, 0, Y0,   P_Y,  0);
    step("hold.y1", 1, 4'b0101, 0, Y0,   P_Y,  0);
    step("hold.ar", 1, 4'b0101, 0, L_AR, P_AR, 0);
    step("hold.g2", 1, 4'b0101, 0, G2,   P_G,  2);

    // Emergency raised at green count 1.
    do_reset("rst4");
    step("em.g0", 1, 4'b1111, 0, G0, P_G, 0);
    step("em.g1", 1, 4'b1111, 0, G0, P_G, 0);
    step("em.y0", 1, 4'b1111, 1, Y0, P_Y, 0);
    step("em.y1", 1, 4'b1111, 1, Y0, P_Y, 0);
    for (int i = 0; i < 20; i++)
      step($sformatf("em.ar[%0d]", i), 1, 4'b1111, 1, L_AR, P_AR, 0);
    step("em.rel", 1, 4'b1111, 0, G1, P_G, 1);

    // Tick gating: tick once every three cycles -> 12-cycle green.
    do_reset("rst5");
    for (int c = 0; c < 12; c++)
      step($sformatf("gate.g[%0d]", c), (c % 3) == 0, 4'b1111, 0, G0, P_G, 0);
    // Emergency with tick low must not act until a tick arrives.
    for (int c = 12; c < 15; c++)
      step($sformatf("gate.y[%0d]", c), (c % 3) == 0, 4'b1111, c == 14,
           Y0, P_Y, 0);

    // Reset mid-yellow: all-red at once, approach 0 granted first after.
    do_reset("rst6");
    step("post.g0", 1, 4'b1111, 0, G0, P_G, 0);
    step("post.g1", 1, 4'b0001, 0, G0, P_G, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
